// File: rtl/ps2_host_tx_if.sv
// Command/status bundle between a host controller and the PS/2 transmitter.
interface ps2_host_tx_if;
  logic       i_tx_start;
  logic [7:0] i_tx_data;
  logic       o_busy;
  logic       o_done;
  logic       o_ack_err;
  logic       o_timeout_err;

  modport master (
    output i_tx_start, i_tx_data,
    input  o_busy, o_done, o_ack_err, o_timeout_err
  );

  modport slave (
    input  i_tx_start, i_tx_data,
    output o_busy, o_done, o_ack_err, o_timeout_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, bit shifting on
// device clock falling edges, ACK check and start/frame watchdogs.
//
// state       | meaning
// S_IDLE      | lines released, waiting for tx_start
// S_INHIBIT   | clock held low for INHIBIT_CYCLES
// S_RTS       | clock and data (start bit) held low for RTS_CYCLES
// S_SEND      | clock released, one bit presented per device falling edge
// S_WAIT_IDLE | ACK captured, waiting for both lines high
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int RTS_CYCLES     = 200,
  parameter int START_TIMEOUT  = 1500000,
  parameter int FRAME_TIMEOUT  = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave bus,
  input  logic         i_ps2_clk_in,
  input  logic         i_ps2_data_in,
  output logic         o_ps2_clk_oe,
  output logic         o_ps2_data_oe
);

  localparam int MAX_AB  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_CD  = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_ALL + 1);
  localparam int FW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [CW-1:0] INH_LD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] RTS_LD = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] STO_LD = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] FTO_LD = CW'(FRAME_TIMEOUT - 1);
  localparam logic [FW-1:0] FLT_TC = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_WAIT_IDLE
  } state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_f, r_clk_fd, r_dat_f;
  logic [FW-1:0] r_clk_cnt, r_dat_cnt;
  logic          w_fe;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_tmr, w_tmr_nxt;
  logic [CW-1:0] r_to, w_to_nxt;
  logic [3:0]    r_n, w_n_nxt, w_n_inc;
  logic [7:0]    r_byte, w_byte_nxt;
  logic          r_par, w_par_nxt;
  logic          r_ack, w_ack_nxt;
  logic          r_clk_oe, w_clk_oe_nxt;
  logic          r_data_oe, w_data_oe_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_ack_err, w_ack_err_nxt;
  logic          r_to_err, w_to_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data_in;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // A new level is adopted only after FILTER_LEN consecutive samples disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_f   <= 1'b1;
      r_clk_fd  <= 1'b1;
      r_clk_cnt <= '0;
    end else begin
      r_clk_fd <= r_clk_f;
      if (r_clk_s2 == r_clk_f) begin
        r_clk_cnt <= '0;
      end else if (r_clk_cnt == FLT_TC) begin
        r_clk_f   <= r_clk_s2;
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat_f   <= 1'b1;
      r_dat_cnt <= '0;
    end else begin
      if (r_dat_s2 == r_dat_f) begin
        r_dat_cnt <= '0;
      end else if (r_dat_cnt == FLT_TC) begin
        r_dat_f   <= r_dat_s2;
        r_dat_cnt <= '0;
      end else begin
        r_dat_cnt <= r_dat_cnt + 1'b1;
      end
    end
  end

  assign w_fe    = r_clk_fd & ~r_clk_f;
  assign w_n_inc = r_n + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_to      <= '0;
      r_n       <= '0;
      r_byte    <= '0;
      r_par     <= 1'b0;
      r_ack     <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_to_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_to      <= w_to_nxt;
      r_n       <= w_n_nxt;
      r_byte    <= w_byte_nxt;
      r_par     <= w_par_nxt;
      r_ack     <= w_ack_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_to_err  <= w_to_err_nxt;
    end
  end

  // Outputs are registered from the next state so done/ack_err coincide with busy falling.
  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr;
    w_to_nxt      = r_to;
    w_n_nxt       = r_n;
    w_byte_nxt    = r_byte;
    w_par_nxt     = r_par;
    w_ack_nxt     = r_ack;
    w_clk_oe_nxt  = 1'b0;
    w_data_oe_nxt = 1'b0;
    w_busy_nxt    = 1'b1;
    w_done_nxt    = 1'b0;
    w_ack_err_nxt = 1'b0;
    w_to_err_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (bus.i_tx_start) begin
          w_byte_nxt   = bus.i_tx_data;
          w_par_nxt    = ~^bus.i_tx_data;
          w_tmr_nxt    = INH_LD;
          w_state_nxt  = S_INHIBIT;
          w_busy_nxt   = 1'b1;
          w_clk_oe_nxt = 1'b1;
        end
      end
      S_INHIBIT: begin
        w_clk_oe_nxt = 1'b1;
        if (r_tmr == '0) begin
          w_tmr_nxt     = RTS_LD;
          w_state_nxt   = S_RTS;
          w_data_oe_nxt = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      S_RTS: begin
        w_clk_oe_nxt  = 1'b1;
        w_data_oe_nxt = 1'b1;
        if (r_tmr == '0) begin
          w_clk_oe_nxt = 1'b0;
          w_n_nxt      = '0;
          w_to_nxt     = STO_LD;
          w_state_nxt  = S_SEND;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      S_SEND: begin
        w_data_oe_nxt = r_data_oe;
        if (r_to == '0) begin
          w_to_err_nxt  = 1'b1;
          w_data_oe_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_to_nxt = r_to - 1'b1;
          if (w_fe) begin
            w_n_nxt = w_n_inc;
            if (r_n == 4'd0) w_to_nxt = FTO_LD;
            if (w_n_inc <= 4'd8) begin
              w_data_oe_nxt = ~r_byte[r_n[2:0]];
            end else if (w_n_inc == 4'd9) begin
              w_data_oe_nxt = ~r_par;
            end else if (w_n_inc == 4'd10) begin
              w_data_oe_nxt = 1'b0;
            end else begin
              w_data_oe_nxt = 1'b0;
              w_ack_nxt     = r_dat_f;
              w_state_nxt   = S_WAIT_IDLE;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        if (r_to == '0) begin
          w_to_err_nxt = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_to_nxt = r_to - 1'b1;
          if (r_clk_f && r_dat_f) begin
            w_busy_nxt    = 1'b0;
            w_state_nxt   = S_IDLE;
            w_done_nxt    = ~r_ack;
            w_ack_err_nxt = r_ack;
          end
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_ps2_clk_oe      = r_clk_oe;
  assign o_ps2_data_oe     = r_data_oe;
  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
  assign bus.o_ack_err     = r_ack_err;
  assign bus.o_timeout_err = r_to_err;

endmodule
